// File: rtl/sdrc_bram_responder.sv
// Block-RAM backed responder for an SDRAM-controller user port: command ack timing,
// init delay, byte-masked write bursts and latency-shifted read bursts.
module sdrc_bram_responder #(
  parameter int unsigned AddressBitWidth = 10,
  parameter int unsigned ReadLatency     = 2,
  parameter int unsigned AckDelay        = 1,
  parameter int unsigned InitCycles      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_sdrc_cmd_en,
  input  logic [2:0]  I_sdrc_cmd,
  input  logic [20:0] I_sdrc_addr,
  input  logic [7:0]  I_sdrc_data_len,
  input  logic [31:0] I_sdrc_data,
  input  logic [3:0]  I_sdrc_dqm,
  output logic [31:0] O_sdrc_data,
  output logic        O_sdrc_init_done,
  output logic        O_sdrc_cmd_ack,
  output logic        cmd_error
);

  localparam int unsigned Depth = 2 ** AddressBitWidth;
  localparam int unsigned InitW = $clog2(InitCycles + 1) + 1;

  localparam logic [2:0] CmdRefresh  = 3'b001;
  localparam logic [2:0] CmdActivate = 3'b011;
  localparam logic [2:0] CmdWrite    = 3'b100;
  localparam logic [2:0] CmdRead     = 3'b101;

  typedef enum logic [1:0] {Idle, WriteBurst, ReadWait, ReadBurst} state_e;

  state_e                     state_q, state_d;
  logic [AddressBitWidth-1:0] addr_q, addr_d;
  logic [7:0]                 len_q, len_d;
  logic [2:0]                 wait_q, wait_d;
  logic                       row_open_q, row_open_d;
  logic                       err_q, err_d;
  logic [AckDelay-1:0]        ack_pipe_q, ack_pipe_d;
  logic                       ack_q;
  logic [InitW-1:0]           init_cnt_q;
  logic                       init_done_q;
  logic [31:0]                rdata_q;

  logic                       accept;
  logic                       mem_we;
  logic                       rd_en;
  logic [AddressBitWidth-1:0] mem_waddr;
  logic [AddressBitWidth-1:0] cmd_addr;
  logic                       unused_addr;

  logic [31:0] mem [Depth];

  assign cmd_addr    = I_sdrc_addr[AddressBitWidth-1:0];
  assign unused_addr = ^I_sdrc_addr[20:AddressBitWidth];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wait_d     = wait_q;
    row_open_d = row_open_q;
    err_d      = err_q;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    rd_en      = 1'b0;

    unique case (state_q)
      Idle: begin
        if (I_sdrc_cmd_en) begin
          // Until init completes only refresh is honoured.
          if (!init_done_q && (I_sdrc_cmd != CmdRefresh)) begin
            err_d = 1'b1;
          end else begin
            accept = 1'b1;
            case (I_sdrc_cmd)
              CmdRefresh:  row_open_d = 1'b0;
              CmdActivate: row_open_d = 1'b1;
              CmdWrite: begin
                if (!row_open_q) err_d = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = cmd_addr;
                addr_d    = cmd_addr + 1'b1;
                len_d     = I_sdrc_data_len;
                if (I_sdrc_data_len != 8'd0) state_d = WriteBurst;
              end
              CmdRead: begin
                if (!row_open_q) err_d = 1'b1;
                addr_d  = cmd_addr;
                len_d   = I_sdrc_data_len;
                wait_d  = 3'(ReadLatency - 1);
                state_d = (ReadLatency == 1) ? ReadBurst : ReadWait;
              end
              default: ;
            endcase
          end
        end
      end
      WriteBurst: begin
        if (I_sdrc_cmd_en) err_d = 1'b1;
        mem_we = 1'b1;
        addr_d = addr_q + 1'b1;
        len_d  = len_q - 1'b1;
        if (len_q == 8'd1) state_d = Idle;
      end
      ReadWait: begin
        if (I_sdrc_cmd_en) err_d = 1'b1;
        wait_d = wait_q - 1'b1;
        if (wait_q == 3'd1) state_d = ReadBurst;
      end
      ReadBurst: begin
        if (I_sdrc_cmd_en) err_d = 1'b1;
        rd_en  = 1'b1;
        addr_d = addr_q + 1'b1;
        len_d  = len_q - 1'b1;
        if (len_q == 8'd0) state_d = Idle;
      end
    endcase

    // Ack delay line runs independently of the burst FSM.
    ack_pipe_d    = ack_pipe_q << 1;
    ack_pipe_d[0] = accept;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= Idle;
      addr_q      <= '0;
      len_q       <= '0;
      wait_q      <= '0;
      row_open_q  <= 1'b0;
      err_q       <= 1'b0;
      ack_pipe_q  <= '0;
      ack_q       <= 1'b0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wait_q     <= wait_d;
      row_open_q <= row_open_d;
      err_q      <= err_d;
      ack_pipe_q <= ack_pipe_d;
      ack_q      <= ack_pipe_q[AckDelay-1];
      if (!init_done_q) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (init_cnt_q == InitW'(InitCycles)) init_done_q <= 1'b1;
      end
      if (rd_en) rdata_q <= mem[addr_q];
    end
  end

  // No reset on the array; a word landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!I_sdrc_dqm[b]) mem[mem_waddr][8*b +: 8] <= I_sdrc_data[8*b +: 8];
      end
    end
  end

  assign O_sdrc_data      = rdata_q;
  assign O_sdrc_init_done = init_done_q;
  assign O_sdrc_cmd_ack   = ack_q;
  assign cmd_error        = err_q;

endmodule

// File: tb/tb_sdrc_bram_responder.sv
// Directed plus randomized bench for sdrc_bram_responder, checked against an array memory
// model and a cycle-count model of ack, init and error behaviour.
module tb_sdrc_bram_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned RL    = 2;
  localparam int unsigned AD    = 1;
  localparam int unsigned IC    = 16;
  localparam int unsigned Depth = 1 << AW;

  localparam logic [2:0] CRef = 3'b001;
  localparam logic [2:0] CAct = 3'b011;
  localparam logic [2:0] CWr  = 3'b100;
  localparam logic [2:0] CRd  = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_en = 1'b0;
  logic [2:0]  cmd = '0;
  logic [20:0] addr = '0;
  logic [7:0]  len = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  dqm = '0;
  logic [31:0] rdata;
  logic        init_done;
  logic        ack;
  logic        err;

  int checks = 0;
  int failures = 0;
  int rel = 0;

  logic [31:0] mem_m [Depth];
  logic        row_m = 1'b0;
  logic        err_m = 1'b0;
  logic [31:0] last_m = '0;

  always #5 clk = ~clk;

  sdrc_bram_responder #(
    .AddressBitWidth(AW),
    .ReadLatency    (RL),
    .AckDelay       (AD),
    .InitCycles     (IC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .I_sdrc_cmd_en   (cmd_en),
    .I_sdrc_cmd      (cmd),
    .I_sdrc_addr     (addr),
    .I_sdrc_data_len (len),
    .I_sdrc_data     (wdata),
    .I_sdrc_dqm      (dqm),
    .O_sdrc_data     (rdata),
    .O_sdrc_init_done(init_done),
    .O_sdrc_cmd_ack  (ack),
    .cmd_error       (err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h (cycle %0d after reset)", tag, obs, want, rel);
    end
  endtask

  task automatic check1(string tag, logic obs, logic want);
    check(tag, {31'd0, obs}, {31'd0, want});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
  endtask

  function automatic void mwrite(int unsigned idx, logic [31:0] d, logic [3:0] m);
    for (int b = 0; b < 4; b++) begin
      if (!m[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // Called right after an edge sampled rst_n=0; releases reset on the following edge.
  task automatic reset_tail(string tag);
    row_m  = 1'b0;
    err_m  = 1'b0;
    last_m = '0;
    check({tag, "_rst_data"}, rdata, 32'd0);
    check1({tag, "_rst_ack"}, ack, 1'b0);
    check1({tag, "_rst_init"}, init_done, 1'b0);
    check1({tag, "_rst_err"}, err, 1'b0);
    rst_n = 1'b1;
    step();
    rel = 0;
  endtask

  task automatic do_reset(string tag);
    rst_n  = 1'b0;
    cmd_en = 1'b0;
    step();
    step();
    reset_tail(tag);
  endtask

  task automatic init_seq(string tag);
    check1({tag, "_init"}, init_done, (rel >= int'(IC)));
    while (rel < int'(IC) + 2) begin
      step();
      check1({tag, "_init"}, init_done, (rel >= int'(IC)));
    end
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_hold"}, rdata, last_m);
      check1({tag, "_idle_ack"}, ack, 1'b0);
    end
  endtask

  task automatic simple_cmd(string tag, logic [2:0] c);
    bit acc;
    acc    = (rel >= int'(IC)) || (c == CRef);
    cmd_en = 1'b1;
    cmd    = c;
    step();
    cmd_en = 1'b0;
    if (acc) begin
      if (c == CRef) row_m = 1'b0;
      if (c == CAct) row_m = 1'b1;
    end else begin
      err_m = 1'b1;
    end
    check1({tag, "_ack0"}, ack, 1'b0);
    for (int j = 1; j <= int'(AD); j++) begin
      step();
      check1({tag, "_ack"}, ack, acc && (j == int'(AD)));
    end
    check1({tag, "_err"}, err, err_m);
  endtask

  // Write burst; seq selects base+k data, otherwise random words.
  task automatic wr_burst(string tag, logic [20:0] a, int n, logic [31:0] base, bit seq,
                          logic [3:0] m, int inj_at = -1, int rst_at = -1);
    logic [31:0] d;
    int unsigned idx;
    for (int k = 0; k <= n; k++) begin
      d     = seq ? base + 32'(k) : $urandom();
      wdata = d;
      dqm   = m;
      if (k == 0) begin
        cmd_en = 1'b1;
        cmd    = CWr;
        addr   = a;
        len    = 8'(n);
      end else if (k == inj_at) begin
        cmd_en = 1'b1;
        cmd    = CRd;
        addr   = 21'($urandom());
      end
      if (k == rst_at) rst_n = 1'b0;
      step();
      cmd_en = 1'b0;
      if (k == rst_at) begin
        reset_tail({tag, "_midrst"});
        return;
      end
      if (k == 0 && !row_m) err_m = 1'b1;
      if (k == inj_at) err_m = 1'b1;
      idx = (32'(a) + 32'(k)) % Depth;
      mwrite(idx, d, m);
      check1({tag, "_ack"}, ack, (k == int'(AD)));
    end
    for (int k = n + 1; k <= int'(AD); k++) begin
      step();
      check1({tag, "_ack"}, ack, (k == int'(AD)));
    end
    check1({tag, "_err"}, err, err_m);
  endtask

  task automatic rd_burst(string tag, logic [20:0] a, int n, int inj_at = -1,
                          logic [20:0] inj_addr = '0);
    bit acc;
    int unsigned idx;
    logic [31:0] want;
    acc    = (rel >= int'(IC));
    cmd_en = 1'b1;
    cmd    = CRd;
    addr   = a;
    len    = 8'(n);
    step();
    cmd_en = 1'b0;
    if (!acc || !row_m) err_m = 1'b1;
    check1({tag, "_ack0"}, ack, 1'b0);
    if (!acc) begin
      step();
      check1({tag, "_noack"}, ack, 1'b0);
      check({tag, "_nodata"}, rdata, last_m);
      check1({tag, "_err"}, err, err_m);
      return;
    end
    for (int j = 1; j <= int'(RL) + n; j++) begin
      if (j == inj_at) begin
        cmd_en = 1'b1;
        cmd    = CWr;
        addr   = inj_addr;
        len    = 8'd0;
        wdata  = $urandom();
        dqm    = 4'h0;
      end
      step();
      cmd_en = 1'b0;
      if (j == inj_at) err_m = 1'b1;
      check1({tag, "_ack"}, ack, (j == int'(AD)));
      if (j >= int'(RL)) begin
        idx  = (32'(a) + 32'(j) - RL) % Depth;
        want = mem_m[idx];
        check({tag, "_data"}, rdata, want);
        last_m = want;
      end
    end
    for (int j = int'(RL) + n + 1; j <= int'(AD); j++) begin
      step();
      check1({tag, "_ack"}, ack, (j == int'(AD)));
    end
    check1({tag, "_err"}, err, err_m);
  endtask

  initial begin
    logic [20:0] ra;
    int          rn;

    // Reset, refresh during init, read rejected before init, init timing.
    do_reset("a");
    simple_cmd("ref_init", CRef);
    rd_burst("rd_preinit", 21'h000100, 3);
    init_seq("a");

    // Fresh reset clears the sticky error.
    do_reset("b");
    init_seq("b");
    simple_cmd("act", CAct);

    // Fill the whole memory so every later read has a known expectation.
    for (int i = 0; i < 4; i++) wr_burst("fill", 21'(i * 256), 255, '0, 1'b0, 4'h0);

    wr_burst("wr_a0", 21'h000100, 7, 32'h000000A0, 1'b1, 4'h0);
    rd_burst("rd_a0", 21'h000100, 7);
    idle("after_rd", 2);

    wr_burst("wr_ff", 21'h000010, 0, 32'hFFFFFFFF, 1'b1, 4'h0);
    wr_burst("wr_dqm", 21'h000010, 0, 32'h12345678, 1'b1, 4'b0101);
    rd_burst("rd_dqm", 21'h000010, 0);

    wr_burst("wr_wrap", 21'h0003FE, 3, '0, 1'b0, 4'h0);
    rd_burst("rd_wrap", 21'h0003FE, 3);
    rd_burst("rd_wrap0", 21'h000000, 1);

    wr_burst("wr_hi", 21'h1FFC55, 2, 32'h5A5A0000, 1'b1, 4'h0);
    rd_burst("rd_hi", 21'h000055, 2);

    rd_burst("rd_256", 21'h000200, 255);

    for (int i = 0; i < 20; i++) begin
      ra = 21'($urandom());
      rn = int'($urandom_range(15, 0));
      if ($urandom_range(1, 0) == 0) begin
        wr_burst("rnd_wr", ra, rn, '0, 1'b0, 4'($urandom_range(15, 0)));
      end else begin
        rd_burst("rnd_rd", ra, rn);
      end
      if ($urandom_range(3, 0) == 0) idle("rnd_idle", 1);
    end

    // Protocol violations: write with no open row, commands during bursts.
    simple_cmd("ref_close", CRef);
    wr_burst("wr_norow", 21'h000300, 1, '0, 1'b0, 4'h0);
    simple_cmd("act2", CAct);
    rd_burst("rd_norow", 21'h000300, 1);
    wr_burst("wr_inj", 21'h000140, 7, '0, 1'b0, 4'h0, 3);
    rd_burst("rd_inj", 21'h000140, 7, 4, 21'h000380);
    rd_burst("rd_untouched", 21'h000380, 0);

    // Reset lands on word 3 of an 8-word write.
    wr_burst("wr_rst", 21'h000200, 7, 32'hC0DE0000, 1'b1, 4'h0, -1, 3);
    init_seq("c");
    simple_cmd("act3", CAct);
    rd_burst("rd_after_rst", 21'h000200, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
